// File: rtl/execute_stage_pkg.sv
// Shared definitions for the MIPS execute stage: datapath widths, EX control
// bit positions, ALU operation codes, forwarding selects and the multiplier
// FSM state type.
package execute_stage_pkg;

  localparam int NB_BITS = 32;
  localparam int NB_REG  = 5;
  localparam int NB_EXEC = 6;
  localparam int NB_MEM  = 3;
  localparam int NB_WB   = 2;

  // EX control word layout: [5] reg_dst, [4] alu_src, [3:0] alu_op
  localparam int EXEC_REG_DST = 5;
  localparam int EXEC_ALU_SRC = 4;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_NOR  = 4'd5,
    ALU_SLT  = 4'd6,
    ALU_SLTU = 4'd7,
    ALU_SLL  = 4'd8,
    ALU_SRL  = 4'd9,
    ALU_SRA  = 4'd10,
    ALU_LUI  = 4'd11,
    ALU_MULT = 4'd12,
    ALU_MFHI = 4'd13,
    ALU_MFLO = 4'd14,
    ALU_JAL  = 4'd15
  } alu_op_t;

  // Forwarding selects; the fourth encoding aliases the register-file value.
  localparam logic [1:0] FWD_REG     = 2'd0;
  localparam logic [1:0] FWD_MEM     = 2'd1;
  localparam logic [1:0] FWD_WB      = 2'd2;
  localparam logic [1:0] FWD_REG_ALT = 2'd3;

  typedef enum logic [1:0] {
    MUL_IDLE = 2'd0,
    MUL_BUSY = 2'd1,
    MUL_DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/execute_stage_mult_seq.sv
// Iterative 32x32 signed multiplier owning the HI/LO registers.
// Ports:
//   clk, rst   clock, synchronous active-high reset (aborts a multiply)
//   start      request; only acted on in IDLE
//   a, b       signed operands, captured in IDLE
//   done       high during the single DONE cycle
//   hi, lo     product registers, written at the DONE edge
//   state      current FSM state (debug visibility)
// Operation: magnitudes are multiplied with 32 shift-add steps (one per BUSY
// cycle) and the sign is applied once when the product is committed.
module mult_seq
  import execute_stage_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [NB_BITS-1:0] a,
  input  logic [NB_BITS-1:0] b,
  output logic               done,
  output logic [NB_BITS-1:0] hi,
  output logic [NB_BITS-1:0] lo,
  output mul_state_t         state
);

  mul_state_t           next_state;
  logic [4:0]           cnt;
  logic [2*NB_BITS-1:0] mcand;
  logic [NB_BITS-1:0]   mplr;
  logic [2*NB_BITS-1:0] acc;
  logic                 sign;
  logic [NB_BITS-1:0]   abs_a;
  logic [NB_BITS-1:0]   abs_b;

  // Negating 0x80000000 yields 0x80000000, which is the correct unsigned
  // magnitude, so the most negative operand needs no special case.
  assign abs_a = a[NB_BITS-1] ? (~a + 1'b1) : a;
  assign abs_b = b[NB_BITS-1] ? (~b + 1'b1) : b;
  assign done  = (state == MUL_DONE);

  always_comb begin
    next_state = state;
    case (state)
      MUL_IDLE: if (start) next_state = MUL_BUSY;
      MUL_BUSY: if (cnt == 5'd31) next_state = MUL_DONE;
      MUL_DONE: next_state = MUL_IDLE;
      default:  next_state = MUL_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MUL_IDLE;
      cnt   <= '0;
      mcand <= '0;
      mplr  <= '0;
      acc   <= '0;
      sign  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      state <= next_state;
      case (state)
        MUL_IDLE: begin
          if (start) begin
            mcand <= {{NB_BITS{1'b0}}, abs_a};
            mplr  <= abs_b;
            acc   <= '0;
            sign  <= a[NB_BITS-1] ^ b[NB_BITS-1];
            cnt   <= '0;
          end
        end
        MUL_BUSY: begin
          if (mplr[0]) acc <= acc + mcand;
          mcand <= mcand << 1;
          mplr  <= mplr >> 1;
          cnt   <= cnt + 5'd1;
        end
        MUL_DONE: begin
          {hi, lo} <= sign ? (~acc + 64'd1) : acc;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS pipeline.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_pc .. i_rd_num      ID/EX register contents (PC+4, operands, controls)
//   i_fwd_a, i_fwd_b      forwarding selects (0/3 reg, 1 EX/MEM, 2 WB)
//   i_mem_fwd, i_wb_fwd   forwarded values from later stages
//   o_ex_mem_*            EX/MEM pipeline register
//   o_stall               combinational hold for PC, IF/ID and ID/EX
// Handshake: o_stall is high while a MULT occupies EX and its product is not
// yet being committed; upstream must hold ID/EX unchanged while it is high.
// The cycle in which o_stall drops (DONE) still carries MULT, and the next
// instruction enters on that edge.
module execute_stage
  import execute_stage_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NB_BITS-1:0] i_pc,
  input  logic [NB_BITS-1:0] i_rs,
  input  logic [NB_BITS-1:0] i_rt,
  input  logic [NB_BITS-1:0] i_sgext,
  input  logic [NB_EXEC-1:0] i_exec,
  input  logic [NB_MEM-1:0]  i_mem,
  input  logic [NB_WB-1:0]   i_wb,
  input  logic [NB_REG-1:0]  i_rt_num,
  input  logic [NB_REG-1:0]  i_rd_num,
  input  logic [1:0]         i_fwd_a,
  input  logic [1:0]         i_fwd_b,
  input  logic [NB_BITS-1:0] i_mem_fwd,
  input  logic [NB_BITS-1:0] i_wb_fwd,
  output logic [NB_BITS-1:0] o_ex_mem_alu,
  output logic [NB_BITS-1:0] o_ex_mem_st,
  output logic [NB_REG-1:0]  o_ex_mem_reg_dst,
  output logic [NB_MEM-1:0]  o_ex_mem_mem,
  output logic [NB_WB-1:0]   o_ex_mem_wb,
  output logic               o_stall
);

  alu_op_t            alu_op;
  logic               reg_dst_sel;
  logic               alu_src_sel;
  logic [4:0]         shamt;
  logic               is_mult;
  logic [NB_BITS-1:0] opnd_a;
  logic [NB_BITS-1:0] fwd_b_val;
  logic [NB_BITS-1:0] opnd_b;
  logic [NB_BITS-1:0] alu_result;
  logic [NB_REG-1:0]  dst_num;
  logic [NB_BITS-1:0] hi;
  logic [NB_BITS-1:0] lo;
  logic               mul_done;
  mul_state_t         mul_state;

  assign alu_op      = alu_op_t'(i_exec[3:0]);
  assign reg_dst_sel = i_exec[EXEC_REG_DST];
  assign alu_src_sel = i_exec[EXEC_ALU_SRC];
  assign shamt       = i_sgext[10:6];
  assign is_mult     = (alu_op == ALU_MULT);
  assign dst_num     = reg_dst_sel ? i_rd_num : i_rt_num;

  always_comb begin
    opnd_a = i_rs;
    case (i_fwd_a)
      FWD_MEM: opnd_a = i_mem_fwd;
      FWD_WB:  opnd_a = i_wb_fwd;
      default: opnd_a = i_rs;
    endcase
  end

  always_comb begin
    fwd_b_val = i_rt;
    case (i_fwd_b)
      FWD_MEM: fwd_b_val = i_mem_fwd;
      FWD_WB:  fwd_b_val = i_wb_fwd;
      default: fwd_b_val = i_rt;
    endcase
  end

  assign opnd_b = alu_src_sel ? i_sgext : fwd_b_val;

  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_ADD:  alu_result = opnd_a + opnd_b;
      ALU_SUB:  alu_result = opnd_a - opnd_b;
      ALU_AND:  alu_result = opnd_a & opnd_b;
      ALU_OR:   alu_result = opnd_a | opnd_b;
      ALU_XOR:  alu_result = opnd_a ^ opnd_b;
      ALU_NOR:  alu_result = ~(opnd_a | opnd_b);
      ALU_SLT:  alu_result = {31'd0, $signed(opnd_a) < $signed(opnd_b)};
      ALU_SLTU: alu_result = {31'd0, opnd_a < opnd_b};
      ALU_SLL:  alu_result = opnd_b << shamt;
      ALU_SRL:  alu_result = opnd_b >> shamt;
      ALU_SRA:  alu_result = $unsigned($signed(opnd_b) >>> shamt);
      ALU_LUI:  alu_result = {opnd_b[15:0], 16'h0000};
      ALU_MFHI: alu_result = hi;
      ALU_MFLO: alu_result = lo;
      ALU_JAL:  alu_result = i_pc + 32'd4;
      default:  alu_result = '0;
    endcase
  end

  mult_seq u_mult (
    .clk   (i_clk),
    .rst   (i_rst),
    .start (is_mult && (mul_state == MUL_IDLE)),
    .a     (opnd_a),
    .b     (opnd_b),
    .done  (mul_done),
    .hi    (hi),
    .lo    (lo),
    .state (mul_state)
  );

  assign o_stall = is_mult && !mul_done;

  // MULT never writes a GPR: every cycle it sits in EX, including DONE,
  // sends a bubble downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst || is_mult) begin
      o_ex_mem_alu     <= '0;
      o_ex_mem_st      <= '0;
      o_ex_mem_reg_dst <= '0;
      o_ex_mem_mem     <= '0;
      o_ex_mem_wb      <= '0;
    end else begin
      o_ex_mem_alu     <= alu_result;
      o_ex_mem_st      <= fwd_b_val;
      o_ex_mem_reg_dst <= dst_num;
      o_ex_mem_mem     <= i_mem;
      o_ex_mem_wb      <= i_wb;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
  import execute_stage_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic [31:0] i_pc = '0, i_rs = '0, i_rt = '0, i_sgext = '0;
  logic [5:0]  i_exec = '0;
  logic [2:0]  i_mem = '0;
  logic [1:0]  i_wb = '0;
  logic [4:0]  i_rt_num = '0, i_rd_num = '0;
  logic [1:0]  i_fwd_a = '0, i_fwd_b = '0;
  logic [31:0] i_mem_fwd = '0, i_wb_fwd = '0;
  logic [31:0] o_ex_mem_alu, o_ex_mem_st;
  logic [4:0]  o_ex_mem_reg_dst;
  logic [2:0]  o_ex_mem_mem;
  logic [1:0]  o_ex_mem_wb;
  logic        o_stall;

  int n_assert = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_hi = '0, m_lo = '0;

  execute_stage dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_pc(i_pc), .i_rs(i_rs), .i_rt(i_rt),
    .i_sgext(i_sgext), .i_exec(i_exec), .i_mem(i_mem), .i_wb(i_wb),
    .i_rt_num(i_rt_num), .i_rd_num(i_rd_num), .i_fwd_a(i_fwd_a),
    .i_fwd_b(i_fwd_b), .i_mem_fwd(i_mem_fwd), .i_wb_fwd(i_wb_fwd),
    .o_ex_mem_alu(o_ex_mem_alu), .o_ex_mem_st(o_ex_mem_st),
    .o_ex_mem_reg_dst(o_ex_mem_reg_dst), .o_ex_mem_mem(o_ex_mem_mem),
    .o_ex_mem_wb(o_ex_mem_wb), .o_stall(o_stall)
  );

  // clock / reset
  always #5 i_clk = ~i_clk;

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  // reference model
  function automatic logic [31:0] src_a();
    logic [31:0] s[4];
    s = '{i_rs, i_mem_fwd, i_wb_fwd, i_rs};
    return s[i_fwd_a];
  endfunction

  function automatic logic [31:0] src_b_fwd();
    logic [31:0] s[4];
    s = '{i_rt, i_mem_fwd, i_wb_fwd, i_rt};
    return s[i_fwd_b];
  endfunction

  function automatic logic [31:0] opnd_b();
    return i_exec[4] ? i_sgext : src_b_fwd();
  endfunction

  function automatic logic [31:0] model_result();
    logic [31:0] a, b;
    longint unsigned ub, p2;
    longint sb;
    int sh;
    a  = src_a();
    b  = opnd_b();
    sh = int'(i_sgext[10:6]);
    ub = longint'(b);
    sb = longint'($signed(b));
    p2 = 64'd1 << sh;
    case (int'(i_exec[3:0]))
      0:  return a + b;
      1:  return a - b;
      2:  return a & b;
      3:  return a | b;
      4:  return a ^ b;
      5:  return ~(a | b);
      6:  return (longint'($signed(a)) < sb) ? 32'd1 : 32'd0;
      7:  return (longint'(a) < longint'(ub)) ? 32'd1 : 32'd0;
      8:  return 32'(ub * p2);
      9:  return 32'(ub / p2);
      10: return 32'((sb < 0) ? ((sb - longint'(p2) + 1) / longint'(p2)) : (sb / longint'(p2)));
      11: return 32'((ub % 65536) * 65536);
      13: return m_hi;
      14: return m_lo;
      15: return i_pc + 32'd4;
      default: return 32'd0;
    endcase
  endfunction

  // driver tasks
  task automatic drive(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [31:0] sg, input logic [1:0] fa, input logic [1:0] fb,
                       input logic src, input logic dst);
    i_exec  = {dst, src, op};
    i_rs    = rs;
    i_rt    = rt;
    i_sgext = sg;
    i_fwd_a = fa;
    i_fwd_b = fb;
  endtask

  // issue one non-MULT instruction and score the EX/MEM register
  task automatic issue(input string tag);
    logic [31:0] e_st;
    logic [4:0]  e_dst;
    logic [2:0]  e_mem;
    logic [1:0]  e_wb;
    exp_q.push_back(model_result());
    e_st  = src_b_fwd();
    e_dst = i_exec[5] ? i_rd_num : i_rt_num;
    e_mem = i_mem;
    e_wb  = i_wb;
    #1;
    check({tag, "_stall"}, 32'(o_stall), 32'd0);
    tick();
    check({tag, "_alu"}, o_ex_mem_alu, exp_q.pop_front());
    check({tag, "_st"}, o_ex_mem_st, e_st);
    check({tag, "_dst"}, 32'(o_ex_mem_reg_dst), 32'(e_dst));
    check({tag, "_mem"}, 32'(o_ex_mem_mem), 32'(e_mem));
    check({tag, "_wb"}, 32'(o_ex_mem_wb), 32'(e_wb));
  endtask

  // run a MULT already driven on the inputs through to its commit edge
  task automatic run_mult(input string tag);
    longint prod;
    int stall_cycles;
    prod = longint'($signed(src_a())) * longint'($signed(opnd_b()));
    stall_cycles = 0;
    #1;
    for (int i = 0; i < 100; i++) begin
      if (!o_stall) break;
      stall_cycles++;
      tick();
      check({tag, "_bubble_wb"}, 32'(o_ex_mem_wb), 32'd0);
    end
    check({tag, "_stall_cycles"}, 32'(stall_cycles), 32'd33);
    tick();
    check({tag, "_done_bubble_wb"}, 32'(o_ex_mem_wb), 32'd0);
    check({tag, "_done_bubble_alu"}, o_ex_mem_alu, 32'd0);
    m_hi = prod[63:32];
    m_lo = prod[31:0];
    i_exec = {2'b00, 4'd0};
  endtask

  initial begin
    // reset state after nonzero outputs
    i_mem = 3'd7; i_wb = 2'd3; i_rt_num = 5'd9; i_rd_num = 5'd7;
    drive(4'd0, 32'd1, 32'd2, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_alu", o_ex_mem_alu, 32'd0);
    check("rst_st", o_ex_mem_st, 32'd0);
    check("rst_dst", 32'(o_ex_mem_reg_dst), 32'd0);
    check("rst_mem", 32'(o_ex_mem_mem), 32'd0);
    check("rst_wb", 32'(o_ex_mem_wb), 32'd0);
    check("rst_stall", 32'(o_stall), 32'd0);

    // ADD/SUB/SLT/SLTU with A=5, B=-3, rd=7
    i_mem = 3'd2; i_wb = 2'd1; i_rt_num = 5'd3; i_rd_num = 5'd7;
    drive(4'd0, 32'd5, 32'hFFFF_FFFD, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    issue("add"); check("add_const", o_ex_mem_alu, 32'd2);
    check("add_rd7", 32'(o_ex_mem_reg_dst), 32'd7);
    i_exec[3:0] = 4'd1; issue("sub"); check("sub_const", o_ex_mem_alu, 32'd8);
    i_exec[3:0] = 4'd6; issue("slt"); check("slt_const", o_ex_mem_alu, 32'd0);
    i_exec[3:0] = 4'd7; issue("sltu"); check("sltu_const", o_ex_mem_alu, 32'd1);

    // forwarding
    i_mem_fwd = 32'h10; i_wb_fwd = 32'h20;
    drive(4'd0, 32'd1, 32'd9, 32'd1, 2'd1, 2'd0, 1'b1, 1'b0);
    issue("fwd_mem"); check("fwd_mem_const", o_ex_mem_alu, 32'h11);
    i_fwd_a = 2'd2; issue("fwd_wb"); check("fwd_wb_const", o_ex_mem_alu, 32'h21);
    i_fwd_b = 2'd2; issue("fwd_st"); check("fwd_st_const", o_ex_mem_st, 32'h20);
    i_fwd_a = 2'd3; i_fwd_b = 2'd3; issue("fwd_sel3");
    check("fwd_sel3_const", o_ex_mem_alu, 32'd2);

    // MULT -7 * 3, then MFHI / MFLO
    drive(4'd12, 32'hFFFF_FFF9, 32'd3, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    run_mult("mult_neg");
    i_exec[3:0] = 4'd13; issue("mfhi_neg"); check("mfhi_neg_const", o_ex_mem_alu, 32'hFFFF_FFFF);
    i_exec[3:0] = 4'd14; issue("mflo_neg"); check("mflo_neg_const", o_ex_mem_alu, 32'hFFFF_FFEB);

    // reset at BUSY cycle 10 of MULT 6*7
    drive(4'd12, 32'd6, 32'd7, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    #1;
    repeat (11) tick();
    check("mid_stall", 32'(o_stall), 32'd1);
    i_rst = 1'b1;
    i_exec[3:0] = 4'd13;
    tick();
    i_rst = 1'b0;
    m_hi = '0; m_lo = '0;
    check("mid_rst_state", 32'(dut.u_mult.state), 32'(MUL_IDLE));
    issue("mid_mfhi"); check("mid_mfhi_const", o_ex_mem_alu, 32'd0);
    i_exec[3:0] = 4'd14; issue("mid_mflo"); check("mid_mflo_const", o_ex_mem_alu, 32'd0);
    drive(4'd12, 32'd6, 32'd7, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    run_mult("mult_42");
    i_exec[3:0] = 4'd14; issue("mflo_42"); check("mflo_42_const", o_ex_mem_alu, 32'd42);

    // most-negative squared
    drive(4'd12, 32'h8000_0000, 32'h8000_0000, 32'd0, 2'd0, 2'd0, 1'b0, 1'b0);
    run_mult("mult_min");
    i_exec[3:0] = 4'd13; issue("mfhi_min"); check("mfhi_min_const", o_ex_mem_alu, 32'h4000_0000);
    i_exec[3:0] = 4'd14; issue("mflo_min"); check("mflo_min_const", o_ex_mem_alu, 32'd0);

    // shifts and LUI
    drive(4'd8, 32'd0, 32'h8000_0001, 32'h0000_0100, 2'd0, 2'd0, 1'b0, 1'b0);
    issue("sll"); check("sll_const", o_ex_mem_alu, 32'h0000_0010);
    i_exec[3:0] = 4'd9; issue("srl"); check("srl_const", o_ex_mem_alu, 32'h0800_0000);
    i_exec[3:0] = 4'd10; issue("sra"); check("sra_const", o_ex_mem_alu, 32'hF800_0000);
    drive(4'd11, 32'd0, 32'd0, 32'h0000_1234, 2'd0, 2'd0, 1'b1, 1'b0);
    issue("lui"); check("lui_const", o_ex_mem_alu, 32'h1234_0000);
    i_pc = 32'h0040_0010;
    drive(4'd15, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 1'b1);
    issue("jal"); check("jal_const", o_ex_mem_alu, 32'h0040_0014);

    // randomized traffic against the model
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = 4'($urandom_range(0, 15));
      i_pc      = $urandom;
      i_mem_fwd = $urandom;
      i_wb_fwd  = $urandom;
      i_mem     = 3'($urandom_range(0, 7));
      i_wb      = 2'($urandom_range(0, 3));
      i_rt_num  = 5'($urandom_range(0, 31));
      i_rd_num  = 5'($urandom_range(0, 31));
      drive(op, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if (op == 4'd12 && n % 4 == 0) run_mult("rnd_mult");
      else begin
        if (op == 4'd12) i_exec[3:0] = 4'd13;
        issue("rnd");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
